tmds_decode: RTL and testbench
==============================

TMDS_DECODE -- requirements
Module: tmds_decode

Interface
REQ-001 SHALL have parameter LOCK_RUN, default 8: consecutive control tokens required to declare alignment.
REQ-002 SHALL have parameter SEARCH_TIMEOUT, default 1023: cycles at one offset without lock before the offset advances.
REQ-003 SHALL have parameter LOSS_TIMEOUT, default 4095: cycles in LOCKED without a qualifying token run before lock is dropped.
REQ-004 SHALL have port pixelclk, input, 1 bit: the single clock, one 10-bit word per cycle.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port raw_din, input, 10 bits: unaligned deserialized word; bit 0 is earliest on the wire.
REQ-007 SHALL have port dout, output, 8 bits: decoded pixel data.
REQ-008 SHALL have ports c0 and c1, outputs, 1 bit each: decoded control bits.
REQ-009 SHALL have port de, output, 1 bit: data enable.
REQ-010 SHALL have port locked, output, 1 bit: word alignment achieved.
REQ-011 SHALL have port offset, output, 4 bits: current alignment offset, range 0..9.

Function
REQ-012 SHALL register raw_din into prev_q every cycle and form window = {raw_din, prev_q} (20 bits); aligned word = window[offset+9:offset].
REQ-013 SHALL classify aligned words as control tokens (bit9..0) as follows:
- CTL0 = 1101010100 -> c1c0 = 00
- CTL1 = 0010101011 -> c1c0 = 01
- CTL2 = 0101010100 -> c1c0 = 10
- CTL3 = 1010101011 -> c1c0 = 11
REQ-014 SHALL decode a non-token word q as follows:
- if q[9]=1, invert q[7:0] first
- d[0] = q[0]
- for i = 1..7: d[i] = q[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1]), using post-inversion bits
REQ-015 SHALL use a two-stage pipeline (aligned-word register, then output register); latency is 3 cycles from raw_din at offset 0 to outputs.
REQ-016 SHALL drive, when the word is a token: de = 0, dout = 0, c1c0 per REQ-013.
REQ-017 SHALL drive, when the word is data: de = 1, dout = decoded value, c0/c1 holding their last token value.
REQ-018 SHALL force de = 0 and dout = 0 while locked = 0; c0/c1 still decode.
REQ-019 SHALL implement FSM states SEARCH, VERIFY, LOCKED, with a run counter (consecutive tokens, saturating at LOCK_RUN) and a search timer.
REQ-020 SEARCH: a token moves the FSM to VERIFY with run = 1; the timer increments every cycle in SEARCH and VERIFY.
REQ-021 VERIFY: a token increments run; run reaching LOCK_RUN moves the FSM to LOCKED, asserts locked on the next edge, and clears the timer; a non-token clears run and returns to SEARCH without changing offset.
REQ-022 On timer = SEARCH_TIMEOUT while not locked: offset increments (9 wraps to 0), and timer and run clear. If a token arrives in the same cycle, the token wins and offset holds.
REQ-023 LOCKED: offset is frozen. The loss timer clears whenever run reaches LOCK_RUN and otherwise increments. Reaching LOSS_TIMEOUT moves the FSM to SEARCH, deasserts locked, and clears both timers; offset holds.

Reset
REQ-024 SHALL, on rst = 1 at a clock edge, set: state SEARCH, offset 0, run 0, both timers 0, prev_q 0, pipeline 0, dout 0, de 0, c0 0, c1 0, locked 0.
REQ-025 SHALL let rst asserted mid-lock take effect on the next edge regardless of state, with no partial output.

Structure
REQ-026 SHALL place CTL0..CTL3 constants and the FSM state encoding in shared package tmds_pkg; the encoder uses the same constants.
REQ-027 SHALL split window formation, token detection and the FSM into sub-module tmds_word_align; decoding stays in tmds_decode.

Verification
REQ-028 Reset: rst = 1 for 2 cycles amid random raw_din -> locked = 0, de = 0, dout = 0x00, offset = 0, c0 = c1 = 0.
REQ-029 Lock at offset 0: 16x CTL0 then 0x100 -> locked = 1 after the 8th token is processed; then de = 1, dout = 0x00 three cycles after 0x100 enters.
REQ-030 Data decode: after lock, feed 0x200 -> dout = 0xFF, de = 1; feed CTL2 -> de = 0, c1 = 1, c0 = 0; feed CTL1 -> c1 = 0, c0 = 1.
REQ-031 Misaligned stream: stream from REQ-029 with alternating CTL0/CTL1 blanking, rotated by 3 bits -> offset settles at 3 within 4x(SEARCH_TIMEOUT+1) cycles; locked = 1; 0x200 word decodes to 0xFF.
REQ-032 Loss of lock: after lock, 4096 consecutive data words, no tokens -> locked falls exactly LOSS_TIMEOUT cycles after the last token run; de = 0 thereafter; offset unchanged.
REQ-033 Reset mid-lock: rst = 1 for 1 cycle while LOCKED with de = 1 -> next cycle locked = 0, offset = 0, de = 0; relock per REQ-029 follows.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared TMDS constants, alignment FSM encoding and word-level helpers.
package tmds_pkg;

  // Control tokens, bit 9 down to bit 0 (bit 0 is first on the wire).
  localparam logic [9:0] CTL0 = 10'b1101010100;
  localparam logic [9:0] CTL1 = 10'b0010101011;
  localparam logic [9:0] CTL2 = 10'b0101010100;
  localparam logic [9:0] CTL3 = 10'b1010101011;

  typedef enum logic [1:0] {
    StSearch = 2'd0,
    StVerify = 2'd1,
    StLocked = 2'd2
  } align_state_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] code;  // {c1, c0}
  } ctl_tok_t;

  // Match a word against the four control tokens.
  function automatic ctl_tok_t ctl_classify(input logic [9:0] w);
    ctl_tok_t t;
    t.valid = 1'b1;
    t.code  = 2'b00;
    case (w)
      CTL0:    t.code = 2'b00;
      CTL1:    t.code = 2'b01;
      CTL2:    t.code = 2'b10;
      CTL3:    t.code = 2'b11;
      default: t.valid = 1'b0;
    endcase
    return t;
  endfunction

  // Undo the TMDS transition-minimising encoding of a data word.
  function automatic logic [7:0] decode_data(input logic [9:0] q);
    logic [7:0] b;
    logic [7:0] d;
    b    = q[9] ? ~q[7:0] : q[7:0];
    d[0] = b[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = q[8] ? (b[i] ^ b[i-1]) : ~(b[i] ^ b[i-1]);
    end
    return d;
  endfunction

endpackage

// File: rtl/tmds_word_align.sv
// Word alignment: 20-bit window, token detection and SEARCH/VERIFY/LOCKED FSM.
module tmds_word_align
  import tmds_pkg::*;
#(
  parameter int unsigned LOCK_RUN       = 8,
  parameter int unsigned SEARCH_TIMEOUT = 1023,
  parameter int unsigned LOSS_TIMEOUT   = 4095
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [9:0] raw_i,
  output logic [9:0] aligned_o,
  output logic       tok_o,
  output logic [1:0] ctl_o,
  output logic       locked_o,
  output logic [3:0] offset_o
);

  localparam int unsigned RunW   = $clog2(LOCK_RUN + 1);
  localparam int unsigned TimerW = $clog2(SEARCH_TIMEOUT + 1);
  localparam int unsigned LossW  = $clog2(LOSS_TIMEOUT + 1);

  localparam logic [RunW-1:0]   RunMax   = RunW'(LOCK_RUN);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(SEARCH_TIMEOUT);
  localparam logic [LossW-1:0]  LossMax  = LossW'(LOSS_TIMEOUT);

  logic [9:0]        prev_q, prev_d;
  logic [9:0]        aligned_q, aligned_d;
  logic              tok_q, tok_d;
  logic [1:0]        ctl_q, ctl_d;
  align_state_e      state_q, state_d;
  logic [RunW-1:0]   run_q, run_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [LossW-1:0]  loss_q, loss_d;
  logic [3:0]        offset_q, offset_d;
  logic              locked_q, locked_d;

  logic [19:0]       window;
  logic [9:0]        cur_word;
  ctl_tok_t          cur_tok;
  logic [RunW-1:0]   run_inc;
  logic [LossW-1:0]  loss_inc;

  // Window formation and token classification at the current offset.
  always_comb begin
    window    = {raw_i, prev_q};
    cur_word  = 10'(window >> offset_q);
    cur_tok   = ctl_classify(cur_word);
    prev_d    = raw_i;
    aligned_d = cur_word;
    tok_d     = cur_tok.valid;
    ctl_d     = cur_tok.code;
  end

  // Input history and first pipeline stage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q    <= '0;
      aligned_q <= '0;
      tok_q     <= 1'b0;
      ctl_q     <= '0;
    end else begin
      prev_q    <= prev_d;
      aligned_q <= aligned_d;
      tok_q     <= tok_d;
      ctl_q     <= ctl_d;
    end
  end

  // FSM state register together with its counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StSearch;
      run_q    <= '0;
      timer_q  <= '0;
      loss_q   <= '0;
      offset_q <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      timer_q  <= timer_d;
      loss_q   <= loss_d;
      offset_q <= offset_d;
      locked_q <= locked_d;
    end
  end

  // Next-state: token runs, search timeout and loss-of-lock timing.
  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    timer_d  = timer_q;
    loss_d   = loss_q;
    offset_d = offset_q;
    run_inc  = (run_q == RunMax) ? run_q : run_q + RunW'(1);
    loss_inc = loss_q + LossW'(1);
    unique case (state_q)
      StSearch, StVerify: begin
        timer_d = timer_q + TimerW'(1);
        if (cur_tok.valid) begin
          if (state_q == StSearch) begin
            state_d = StVerify;
            run_d   = RunW'(1);
          end else begin
            run_d = run_inc;
          end
          if (run_d == RunMax) begin
            state_d = StLocked;
            timer_d = '0;
            loss_d  = '0;
          end
        end else begin
          state_d = StSearch;
          run_d   = '0;
        end
        // A token arriving on the timeout cycle keeps the current offset.
        if (timer_q == TimerMax && state_d != StLocked) begin
          timer_d = '0;
          if (!cur_tok.valid) begin
            offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
            run_d    = '0;
          end
        end
      end
      StLocked: begin
        run_d = cur_tok.valid ? run_inc : '0;
        if (cur_tok.valid && run_d == RunMax) begin
          loss_d = '0;
        end else if (loss_inc == LossMax) begin
          state_d = StSearch;
          loss_d  = '0;
          timer_d = '0;
          run_d   = '0;
        end else begin
          loss_d = loss_inc;
        end
      end
      default: state_d = StSearch;
    endcase
  end

  // Output decode: locked is a registered view of the next state.
  always_comb begin
    locked_d = (state_d == StLocked);
  end

  assign aligned_o = aligned_q;
  assign tok_o     = tok_q;
  assign ctl_o     = ctl_q;
  assign locked_o  = locked_q;
  assign offset_o  = offset_q;

endmodule

// File: rtl/tmds_decode.sv
// TMDS channel decoder: word alignment followed by token/data decode stage.
module tmds_decode
  import tmds_pkg::*;
#(
  parameter int unsigned LOCK_RUN       = 8,
  parameter int unsigned SEARCH_TIMEOUT = 1023,
  parameter int unsigned LOSS_TIMEOUT   = 4095
) (
  input  logic       pixelclk,
  input  logic       rst,
  input  logic [9:0] raw_din,
  output logic [7:0] dout,
  output logic       c0,
  output logic       c1,
  output logic       de,
  output logic       locked,
  output logic [3:0] offset
);

  logic [9:0] aligned_w;
  logic       tok_w;
  logic [1:0] ctl_w;
  logic       locked_w;
  logic [3:0] offset_w;

  logic [7:0] dout_q, dout_d;
  logic       de_q, de_d;
  logic       c0_q, c0_d;
  logic       c1_q, c1_d;

  tmds_word_align #(
    .LOCK_RUN       (LOCK_RUN),
    .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
    .LOSS_TIMEOUT   (LOSS_TIMEOUT)
  ) u_align (
    .clk_i     (pixelclk),
    .rst_i     (rst),
    .raw_i     (raw_din),
    .aligned_o (aligned_w),
    .tok_o     (tok_w),
    .ctl_o     (ctl_w),
    .locked_o  (locked_w),
    .offset_o  (offset_w)
  );

  // Tokens update c1/c0 and blank data; data passes only while locked.
  always_comb begin
    dout_d = '0;
    de_d   = 1'b0;
    c0_d   = c0_q;
    c1_d   = c1_q;
    if (tok_w) begin
      {c1_d, c0_d} = ctl_w;
    end else if (locked_w) begin
      de_d   = 1'b1;
      dout_d = decode_data(aligned_w);
    end
  end

  // Output register stage.
  always_ff @(posedge pixelclk) begin
    if (rst) begin
      dout_q <= '0;
      de_q   <= 1'b0;
      c0_q   <= 1'b0;
      c1_q   <= 1'b0;
    end else begin
      dout_q <= dout_d;
      de_q   <= de_d;
      c0_q   <= c0_d;
      c1_q   <= c1_d;
    end
  end

  assign dout   = dout_q;
  assign de     = de_q;
  assign c0     = c0_q;
  assign c1     = c1_q;
  assign locked = locked_w;
  assign offset = offset_w;

endmodule

// File: tb/tb_tmds_decode.sv
// Scoreboard bench for tmds_decode with default parameters.
module tb_tmds_decode;

  localparam int unsigned SearchTo = 1023;
  localparam int unsigned LossTo   = 4095;

  localparam logic [9:0] Ctl0W = 10'b1101010100;
  localparam logic [9:0] Ctl1W = 10'b0010101011;
  localparam logic [9:0] Ctl2W = 10'b0101010100;
  localparam logic [9:0] Ctl3W = 10'b1010101011;

  logic       pixelclk = 1'b0;
  logic       rst;
  logic [9:0] raw_din;
  logic [7:0] dout;
  logic       c0, c1, de, locked;
  logic [3:0] offset;

  typedef struct packed {
    logic       chk;
    logic       de;
    logic       c1;
    logic       c0;
    logic [7:0] dout;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [1:0]  last_c;
  logic [9:0]  prev_word;
  logic        rot;

  tmds_decode dut (
    .pixelclk (pixelclk),
    .rst      (rst),
    .raw_din  (raw_din),
    .dout     (dout),
    .c0       (c0),
    .c1       (c1),
    .de       (de),
    .locked   (locked),
    .offset   (offset)
  );

  always #5 pixelclk = ~pixelclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference TMDS data decode.
  function automatic logic [7:0] ref_dec(input logic [9:0] q);
    logic [7:0] b;
    logic [7:0] x;
    b    = q[7:0] ^ {8{q[9]}};
    x    = b ^ (b << 1);
    x    = q[8] ? x : ~x;
    x[0] = b[0];
    return x;
  endfunction

  // {is_token, c1, c0}
  function automatic logic [2:0] ref_tok(input logic [9:0] q);
    case (q)
      10'b1101010100: return 3'b100;
      10'b0010101011: return 3'b101;
      10'b0101010100: return 3'b110;
      10'b1010101011: return 3'b111;
      default:        return 3'b000;
    endcase
  endfunction

  // Drive one word (optionally 3-bit rotated), queue its expected output and
  // compare the word whose result is due after this edge.
  task automatic drive(input logic [9:0] w, input logic chk, input logic lk);
    exp_t       e;
    logic [2:0] t;
    raw_din   = rot ? {w[6:0], prev_word[9:7]} : w;
    prev_word = w;
    t         = ref_tok(w);
    e.chk     = chk;
    if (t[2]) begin
      last_c = t[1:0];
      e.de   = 1'b0;
      e.dout = 8'h00;
    end else begin
      e.de   = lk;
      e.dout = lk ? ref_dec(w) : 8'h00;
    end
    e.c1 = last_c[1];
    e.c0 = last_c[0];
    sb_q.push_back(e);
    @(posedge pixelclk);
    #1;
    if (sb_q.size() == 3) begin
      e = sb_q.pop_front();
      if (e.chk) begin
        check_eq("sb_de", de, e.de);
        check_eq("sb_c1", c1, e.c1);
        check_eq("sb_c0", c0, e.c0);
        check_eq("sb_dout", dout, e.dout);
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      raw_din = 10'($urandom);
      @(posedge pixelclk);
      #1;
    end
    rst = 1'b0;
    sb_q.delete();
    last_c    = 2'b00;
    prev_word = '0;
  endtask

  // 16 CTL0 at offset 0: the 8th token (k=7) is evaluated one edge after it
  // is captured, so locked rises after the edge of k=8.
  task automatic lock_at0();
    for (int k = 0; k < 16; k++) begin
      drive(Ctl0W, 1'b1, 1'b0);
      if (k == 7) check_eq("lock_early", locked, 0);
      if (k == 8) check_eq("lock_rise", locked, 1);
    end
    drive(10'h100, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) drive(Ctl0W, 1'b1, 1'b1);
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    raw_din   = '0;
    rot       = 1'b0;
    last_c    = 2'b00;
    prev_word = '0;

    // Reset amid random input.
    do_reset(2);
    check_eq("rst_locked", locked, 0);
    check_eq("rst_de", de, 0);
    check_eq("rst_dout", dout, 8'h00);
    check_eq("rst_offset", offset, 0);
    check_eq("rst_c0", c0, 0);
    check_eq("rst_c1", c1, 0);

    lock_at0();

    // Data decode and token updates while locked.
    drive(10'h200, 1'b1, 1'b1);
    drive(Ctl2W, 1'b1, 1'b1);
    drive(Ctl1W, 1'b1, 1'b1);
    drive(Ctl3W, 1'b1, 1'b1);
    for (int k = 0; k < 24; k++) drive(10'($urandom), 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) drive(Ctl0W, 1'b1, 1'b1);

    // Reset while data is flowing.
    for (int k = 0; k < 3; k++) drive(10'h200, 1'b1, 1'b1);
    check_eq("pre_rst_de", de, 1);
    do_reset(1);
    check_eq("mid_rst_locked", locked, 0);
    check_eq("mid_rst_offset", offset, 0);
    check_eq("mid_rst_de", de, 0);
    check_eq("mid_rst_dout", dout, 8'h00);
    lock_at0();

    // Loss of lock: last token captured at edge E_t reaches the FSM at
    // E_t+1, then LOSS_TIMEOUT further edges drop locked.
    for (int k = 0; k < 10; k++) drive(Ctl0W, 1'b1, 1'b1);
    n = 0;
    while (locked && n < 5000) begin
      drive(10'h200, 1'b0, 1'b0);
      n++;
    end
    check_eq("loss_edges", n, LossTo + 1);
    check_eq("loss_locked", locked, 0);
    check_eq("loss_offset", offset, 0);
    for (int k = 0; k < 4; k++) drive(10'h200, 1'b1, 1'b0);

    // Stream rotated by 3 bits must settle at offset 3.
    rot = 1'b1;
    do_reset(2);
    n = 0;
    while (!locked && n < 4 * (SearchTo + 1)) begin
      drive((n % 2 == 1) ? Ctl1W : Ctl0W, 1'b0, 1'b0);
      n++;
    end
    check_eq("mis_locked", locked, 1);
    check_eq("mis_in_time", n <= 4 * (SearchTo + 1), 1);
    check_eq("mis_offset", offset, 3);
    drive(Ctl0W, 1'b1, 1'b1);
    drive(Ctl1W, 1'b1, 1'b1);
    drive(10'h200, 1'b1, 1'b1);
    drive(Ctl0W, 1'b1, 1'b1);
    drive(10'h100, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) drive(Ctl1W, 1'b1, 1'b1);
    check_eq("mis_offset_hold", offset, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
